// File: rtl/stall_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stall_mem_responder_pkg
// Brief    : Shared state encodings and latency bounds for the stall responder
// Revision : 1.0  initial release
// ============================================================================
package stall_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int c_LATENCY_MIN = 2;
  localparam int c_LATENCY_MAX = 15;
  localparam int c_DATA_W      = 16;

endpackage
`default_nettype wire

// File: rtl/stall_mem_responder_mem_word_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_array
// Brief    : Single-port word array, combinational read, gated synchronous write
// Revision : 1.0  initial release
// ============================================================================
module mem_word_array
  import stall_mem_responder_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [c_DATA_W-1:0] i_wrData,
  output logic [c_DATA_W-1:0] o_rdData
);

  logic [c_DATA_W-1:0] r_mem [2**IDX_W];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/stall_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : stall_mem_responder
// Brief    : Multi-cycle data-memory responder with stall, done and err pulses
// Revision : 1.0  initial release
// ============================================================================
module stall_mem_responder
  import stall_mem_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                wr,
  input  logic [15:0]         addr,
  input  logic [15:0]         data_in,
  output logic [15:0]         data_out,
  output logic                done,
  output logic                stall,
  output logic                err
);

  localparam logic [3:0] c_LOAD  = 4'(LATENCY - 2);
  localparam bit         c_SHORT = (LATENCY <= c_LATENCY_MIN);

  state_t             r_state, w_stateNext;
  logic [3:0]         r_count, w_countNext;
  logic               r_wrQ, r_errQ;
  logic [IDX_W-1:0]   r_idxQ;
  logic [15:0]        r_dataInQ, r_dataOut;
  logic               w_accept, w_enterResp, w_we;
  logic               w_rdWr, w_rdErr;
  logic [IDX_W-1:0]   w_rdIdx;
  logic [15:0]        w_rdData;

  assign w_accept = (r_state == IDLE) && enable;

  // Requests that jump straight to RESP are read from the live inputs.
  assign w_rdIdx = (r_state == IDLE) ? addr[IDX_W:1] : r_idxQ;
  assign w_rdWr  = (r_state == IDLE) ? wr            : r_wrQ;
  assign w_rdErr = (r_state == IDLE) ? addr[0]       : r_errQ;

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    case (r_state)
      IDLE: begin
        if (enable) begin
          if (addr[0] || c_SHORT) begin
            w_stateNext = RESP;
          end else begin
            w_stateNext = BUSY;
            w_countNext = c_LOAD;
          end
        end
      end
      BUSY: begin
        // r_count is the number of BUSY cycles still to run, including this one.
        w_countNext = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_stateNext = RESP;
        end
      end
      RESP:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_enterResp = (w_stateNext == RESP) && (r_state != RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= 4'd0;
      r_dataOut <= 16'd0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_dataOut <= (w_enterResp && !w_rdWr && !w_rdErr) ? w_rdData : 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrQ     <= 1'b0;
      r_errQ    <= 1'b0;
      r_idxQ    <= '0;
      r_dataInQ <= 16'd0;
    end else if (w_accept) begin
      r_wrQ     <= wr;
      r_errQ    <= addr[0];
      r_idxQ    <= addr[IDX_W:1];
      r_dataInQ <= data_in;
    end
  end

  assign w_we = (r_state == RESP) && r_wrQ && !r_errQ;

  mem_word_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .i_we     (w_we),
    .i_idx    (w_rdIdx),
    .i_wrData (r_dataInQ),
    .o_rdData (w_rdData)
  );

  generate
    if (IDX_W < 15) begin : g_unusedAddr
      logic w_unusedAddrBits;
      assign w_unusedAddrBits = ^addr[15:IDX_W+1];
    end
  endgenerate

  assign done     = (r_state == RESP);
  assign err      = (r_state == RESP) && r_errQ;
  assign stall    = !rst && (w_accept || (r_state == BUSY));
  assign data_out = r_dataOut;

endmodule
`default_nettype wire

// File: tb/tb_stall_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_stall_mem_responder
// Brief    : Self-checking bench: vector table, scoreboard and corner sequences
// Revision : 1.0  initial release
// ============================================================================
module tb_stall_mem_responder;

  localparam int LATENCY = 4;
  localparam int IDX_W   = 8;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] expD;
    logic        expE;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [15:0] data_in = 16'd0;
  logic [15:0] data_out;
  logic        done, stall, err;

  int   nChecks = 0;
  int   nErrors = 0;
  exp_t sb[$];
  vec_t vecs[11];

  stall_mem_responder #(
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .stall    (stall),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request; optionally disturbs addr/data_in during the first BUSY cycle.
  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] expD, input logic expE,
                     input bit corrupt, input logic [15:0] alt);
    int   cyc;
    int   expLat;
    exp_t e;
    expLat = expE ? 1 : LATENCY - 1;
    sb.push_back('{data: expD, err: expE});
    @(negedge clk);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    #1;
    chk("stall_accept", stall, 1);
    chk("done_accept", done, 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        chk("stall_busy", stall, 1);
        chk("quiet_busy", {err, data_out}, 0);
        if (corrupt && cyc == 1) begin
          addr = alt; data_in = ~d;
        end
      end
    end while (!done && cyc < 20);
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", cyc, expLat);
      chk("stall_resp", stall, 0);
      e = sb.pop_front();
      chk("data_out", data_out, e.data);
      chk("err", err, e.err);
    end
    enable = 1'b0;
  endtask

  initial begin
    int   t1, t2;
    exp_t e;

    vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b1, 16'h0202, 16'h1234, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0};
    vecs[6]  = '{1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 16'h0002, 16'h2222, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 16'h0003, 16'hDEAD, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 16'h0002, 16'h0000, 16'h2222, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {done, stall, err, data_out}, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].expD, vecs[i].expE, 1'b0, 16'h0);
    end

    // Reset in the middle of a write leaves the old contents.
    req(1'b1, 16'h0040, 16'h5555, 16'h0000, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'hAAAA;
    repeat (2) @(negedge clk);
    chk("busy_before_rst", stall, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {done, stall, err, data_out}, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("rst_held_outputs", {done, stall, err, data_out}, 0);
    rst = 1'b0;
    repeat (LATENCY) @(negedge clk);
    chk("no_done_after_abort", done, 0);
    req(1'b0, 16'h0040, 16'h0000, 16'h5555, 1'b0, 1'b0, 16'h0);

    // Address changed during BUSY must not affect the access.
    req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 16'h0000);
    req(1'b1, 16'h0040, 16'h7777, 16'h0000, 1'b0, 1'b1, 16'h0010);
    req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    req(1'b0, 16'h0040, 16'h0000, 16'h7777, 1'b0, 1'b0, 16'h0);

    // Back-to-back reads with enable held high.
    sb.push_back('{data: 16'h1111, err: 1'b0});
    sb.push_back('{data: 16'h2222, err: 1'b0});
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = 16'h0000;
    t1 = -1; t2 = -1;
    for (int i = 1; i <= 3 * LATENCY + 4 && t2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        e = sb.pop_front();
        chk("b2b_data", data_out, e.data);
        if (t1 < 0) begin
          t1 = i;
          addr = 16'h0002;
        end else begin
          t2 = i;
        end
      end
    end
    enable = 1'b0;
    chk("b2b_first_latency", t1, LATENCY - 1);
    chk("b2b_gap", t2 - t1, LATENCY);

    @(negedge clk);
    chk("idle_after_b2b", {done, stall, err, data_out}, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
